// File: rtl/brg_pkg.sv
// Shared types and widths for the burst request generator.
// Optional feature macro: BRG_4K_BOUNDARY_EN (no burst crosses a 4 KB page).
package brg_pkg;

    localparam int BRG_BOUNDARY_BYTES = 4096;
    localparam int BRG_SIZE_W         = 13;
    localparam int BRG_LEN_W          = 36;
    localparam int BRG_ADDR_W         = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_UPDATE,
        ST_WAIT,
        ST_DRAIN
    } brg_state_t;

endpackage

// File: rtl/burst_size_calc.sv
// Combinational burst sizing: the smallest of the remaining length, the largest
// legal burst and, when BRG_4K_BOUNDARY_EN is defined, the bytes left before the
// next 4 KB page boundary.
module burst_size_calc
    import brg_pkg::*;
#(
    parameter int MAX_BURST_BYTES = 512
) (
`ifdef BRG_4K_BOUNDARY_EN
    input  logic [11:0]           addr_offset,
`endif
    input  logic [BRG_LEN_W-1:0]  length,
    output logic [BRG_SIZE_W-1:0] size
);

    localparam logic [BRG_SIZE_W-1:0] MAX_BURST = BRG_SIZE_W'(MAX_BURST_BYTES);

    logic [BRG_SIZE_W-1:0] cap;

`ifdef BRG_4K_BOUNDARY_EN
    // Bytes left in the current 4 KB page; a page-aligned address yields a full 4096.
    logic [BRG_SIZE_W-1:0] boundary;
    assign boundary = BRG_SIZE_W'(BRG_BOUNDARY_BYTES) - {1'b0, addr_offset};
`endif

    // The cap fits in 13 bits, so the length comparison is done at full length width.
    always_comb begin
        cap = MAX_BURST;
`ifdef BRG_4K_BOUNDARY_EN
        if (boundary < cap) begin
            cap = boundary;
        end
`endif
        if ({{(BRG_LEN_W-BRG_SIZE_W){1'b0}}, cap} > length) begin
            size = length[BRG_SIZE_W-1:0];
        end else begin
            size = cap;
        end
    end

endmodule

// File: rtl/burst_request_generator.sv
// Slices the incrementer's current region into bursts, issues one read request
// per burst, reports each accepted size back, and limits outstanding requests
// with a credit counter. Optional macro: BRG_4K_BOUNDARY_EN.
module burst_request_generator
    import brg_pkg::*;
#(
    parameter int MAX_BURST_BYTES = 512,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BRG_ADDR_W-1:0] param_address,
    input  logic [BRG_LEN_W-1:0]  param_length,
    input  logic                  param_valid,
    input  logic                  param_complete,
    output logic                  param_update,
    output logic [BRG_LEN_W-1:0]  param_size,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [BRG_ADDR_W-1:0] req_address,
    output logic [BRG_SIZE_W-1:0] req_size,
    input  logic                  rsp_done,
    output logic                  busy,
    output logic                  done
);

    localparam logic [3:0] CREDIT_LIMIT = 4'(MAX_OUTSTANDING);

    brg_state_t            state_q, state_d;
    logic                  param_update_q, param_update_d;
    logic [BRG_LEN_W-1:0]  param_size_q, param_size_d;
    logic                  req_valid_q, req_valid_d;
    logic [BRG_ADDR_W-1:0] req_address_q, req_address_d;
    logic [BRG_SIZE_W-1:0] req_size_q, req_size_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [3:0]            outstanding_q, outstanding_d;
    logic [BRG_SIZE_W-1:0] calc_size;
    logic                  accept;
    logic                  credit_ok;

    burst_size_calc #(
        .MAX_BURST_BYTES(MAX_BURST_BYTES)
    ) u_size_calc (
`ifdef BRG_4K_BOUNDARY_EN
        .addr_offset(param_address[11:0]),
`endif
        .length     (param_length),
        .size       (calc_size)
    );

    assign accept = req_valid_q & req_ready;

    // Credit counter: accept and completion in the same cycle cancel; never underflows.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !rsp_done) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept && rsp_done && (outstanding_q != 4'd0)) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    // Uses next-cycle credit so a completion arriving now lets the request rise next cycle.
    assign credit_ok = (outstanding_d < CREDIT_LIMIT);

    // Next-state and registered-output logic for the burst sequencing FSM.
    always_comb begin
        state_d        = state_q;
        param_update_d = 1'b0;
        param_size_d   = param_size_q;
        req_valid_d    = req_valid_q;
        req_address_d  = req_address_q;
        req_size_d     = req_size_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (param_valid) begin
                    busy_d  = 1'b1;
                    state_d = param_complete ? ST_DRAIN : ST_CALC;
                end
            end
            ST_CALC: begin
                req_address_d = param_address;
                req_size_d    = calc_size;
                req_valid_d   = credit_ok;
                state_d       = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (accept) begin
                    req_valid_d    = 1'b0;
                    param_update_d = 1'b1;
                    param_size_d   = {{(BRG_LEN_W-BRG_SIZE_W){1'b0}}, req_size_q};
                    state_d        = ST_UPDATE;
                end else if (!req_valid_q) begin
                    req_valid_d = credit_ok;
                end
            end
            ST_UPDATE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (param_valid) begin
                    state_d = param_complete ? ST_DRAIN : ST_CALC;
                end
            end
            ST_DRAIN: begin
                if (outstanding_d == 4'd0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, outputs and credit register; synchronous reset drops any pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            param_update_q <= 1'b0;
            param_size_q   <= '0;
            req_valid_q    <= 1'b0;
            req_address_q  <= '0;
            req_size_q     <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            outstanding_q  <= 4'd0;
        end else begin
            state_q        <= state_d;
            param_update_q <= param_update_d;
            param_size_q   <= param_size_d;
            req_valid_q    <= req_valid_d;
            req_address_q  <= req_address_d;
            req_size_q     <= req_size_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            outstanding_q  <= outstanding_d;
        end
    end

    assign param_update = param_update_q;
    assign param_size   = param_size_q;
    assign req_valid    = req_valid_q;
    assign req_address  = req_address_q;
    assign req_size     = req_size_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_burst_request_generator.sv
// Directed bench for burst_request_generator with a small address_incrementer
// model, an auto/manual completion responder and a request/update monitor.
// Expectations follow BRG_4K_BOUNDARY_EN when the bench is built with it.
module tb_burst_request_generator;
    import brg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] param_address = '0;
    logic [35:0] param_length = '0;
    logic        param_valid = 1'b0;
    logic        param_complete = 1'b0;
    logic        param_update;
    logic [35:0] param_size;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [63:0] req_address;
    logic [12:0] req_size;
    logic        rsp_done = 1'b0;
    logic        busy;
    logic        done;

    int testsRun = 0;
    int testsFailed = 0;

    // Stimulus-side command knobs (written only by the main initial block)
    int          startSeq = 0;
    logic [63:0] cmdAddr = '0;
    logic [35:0] cmdLen = '0;
    bit          autoRsp = 1'b0;
    int          manualSeq = 0;

    // Monitor records
    logic [63:0] reqAddrQ[$];
    logic [12:0] reqSizeQ[$];
    logic [35:0] updQ[$];
    int          doneCount = 0;

    burst_request_generator #(
        .MAX_BURST_BYTES(512),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .param_address (param_address),
        .param_length  (param_length),
        .param_valid   (param_valid),
        .param_complete(param_complete),
        .param_update  (param_update),
        .param_size    (param_size),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_address   (req_address),
        .req_size      (req_size),
        .rsp_done      (rsp_done),
        .busy          (busy),
        .done          (done)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Incrementer model: loads a new region, advances on update, hides params for 4 cycles
    int seenSeq = 0;
    int incCnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            param_valid    = 1'b0;
            param_complete = 1'b0;
            incCnt         = 0;
            seenSeq        = startSeq;
        end else if (startSeq != seenSeq) begin
            seenSeq        = startSeq;
            param_address  = cmdAddr;
            param_length   = cmdLen;
            param_valid    = 1'b1;
            param_complete = (cmdLen == 36'd0);
            incCnt         = 0;
        end else if (done) begin
            param_valid    = 1'b0;
            param_complete = 1'b0;
        end else if (param_update) begin
            param_address = param_address + 64'(param_size);
            param_length  = param_length - param_size;
            param_valid   = 1'b0;
            incCnt        = 4;
        end else if (incCnt > 0) begin
            incCnt = incCnt - 1;
            if (incCnt == 0) begin
                param_valid    = 1'b1;
                param_complete = (param_length == 36'd0);
            end
        end
    end

    // Completion responder: auto mode answers each accept after 3 cycles, manual pulses on request
    int pend[$];
    int seenManual = 0;
    always @(negedge clk) begin
        rsp_done = 1'b0;
        foreach (pend[i]) pend[i] = pend[i] - 1;
        if (pend.size() > 0 && pend[0] <= 0) begin
            void'(pend.pop_front());
            rsp_done = 1'b1;
        end
        if (manualSeq != seenManual) begin
            seenManual = manualSeq;
            rsp_done   = 1'b1;
        end
        if (!rst && autoRsp && req_valid && req_ready) begin
            pend.push_back(3);
        end
    end

    // Monitor: records accepted requests, update sizes and done pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (req_valid && req_ready) begin
                reqAddrQ.push_back(req_address);
                reqSizeQ.push_back(req_size);
            end
            if (param_update) updQ.push_back(param_size);
            if (done) doneCount = doneCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [63:0] addr, input logic [35:0] len);
        cmdAddr  = addr;
        cmdLen   = len;
        startSeq = startSeq + 1;
    endtask

    task automatic pulseRsp();
        manualSeq = manualSeq + 1;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int startCount = doneCount;
        int n = 0;
        while (doneCount == startCount && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 64'(doneCount > startCount), 64'd1);
    endtask

    function automatic logic [63:0] reqAddrAt(input int i);
        return (i < reqAddrQ.size()) ? reqAddrQ[i] : '1;
    endfunction

    function automatic logic [63:0] reqSizeAt(input int i);
        return (i < reqSizeQ.size()) ? 64'(reqSizeQ[i]) : '1;
    endfunction

    function automatic logic [63:0] updAt(input int i);
        return (i < updQ.size()) ? 64'(updQ[i]) : '1;
    endfunction

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_req_valid"},    64'(req_valid), 64'd0);
        checkOutput({tag, "_busy"},         64'(busy), 64'd0);
        checkOutput({tag, "_done"},         64'(done), 64'd0);
        checkOutput({tag, "_param_update"}, 64'(param_update), 64'd0);
        checkOutput({tag, "_param_size"},   64'(param_size), 64'd0);
        checkOutput({tag, "_req_address"},  req_address, 64'd0);
        checkOutput({tag, "_req_size"},     64'(req_size), 64'd0);
        checkOutput({tag, "_outstanding"},  64'(dut.outstanding_q), 64'd0);
        checkOutput({tag, "_state"},        64'(dut.state_q), 64'(ST_IDLE));
    endtask

    initial begin
        int baseReq;
        int baseUpd;
        int baseDone;
        logic [63:0] expAddr[3];
        logic [63:0] expSize[3];

        // Reset state
        rst = 1'b1;
        tick(3);
        checkAllClear("reset");
        rst = 1'b0;
        tick(1);

        // Base split: 0x1000 / 1300 bytes -> 512, 512, 276
        req_ready = 1'b1;
        autoRsp   = 1'b1;
        baseReq   = reqAddrQ.size();
        baseUpd   = updQ.size();
        baseDone  = doneCount;
        applyStimulus(64'h1000, 36'd1300);
        tick(1);
        checkOutput("base_calc_no_valid", 64'(req_valid), 64'd0);
        tick(1);
        checkOutput("base_first_valid", 64'(req_valid), 64'd1);
        checkOutput("base_first_addr", req_address, 64'h1000);
        checkOutput("base_first_size", 64'(req_size), 64'd512);
        checkOutput("base_busy", 64'(busy), 64'd1);
        waitDone(400, "base_done_seen");
        tick(10);
        expAddr = '{64'h1000, 64'h1200, 64'h1400};
        expSize = '{64'd512, 64'd512, 64'd276};
        checkOutput("base_req_count", 64'(reqAddrQ.size() - baseReq), 64'd3);
        checkOutput("base_upd_count", 64'(updQ.size() - baseUpd), 64'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("base_req%0d_addr", i), reqAddrAt(baseReq + i), expAddr[i]);
            checkOutput($sformatf("base_req%0d_size", i), reqSizeAt(baseReq + i), expSize[i]);
            checkOutput($sformatf("base_upd%0d_size", i), updAt(baseUpd + i), expSize[i]);
        end
        checkOutput("base_done_count", 64'(doneCount - baseDone), 64'd1);
        checkOutput("base_busy_after", 64'(busy), 64'd0);

        // 4 KB boundary: 0xF80 / 512 bytes
        baseReq = reqAddrQ.size();
        applyStimulus(64'hF80, 36'd512);
        waitDone(400, "bound_done_seen");
        tick(10);
`ifdef BRG_4K_BOUNDARY_EN
        checkOutput("bound_req_count", 64'(reqAddrQ.size() - baseReq), 64'd2);
        checkOutput("bound_req0_addr", reqAddrAt(baseReq), 64'hF80);
        checkOutput("bound_req0_size", reqSizeAt(baseReq), 64'd128);
        checkOutput("bound_req1_addr", reqAddrAt(baseReq + 1), 64'h1000);
        checkOutput("bound_req1_size", reqSizeAt(baseReq + 1), 64'd384);
`else
        checkOutput("bound_req_count", 64'(reqAddrQ.size() - baseReq), 64'd1);
        checkOutput("bound_req0_addr", reqAddrAt(baseReq), 64'hF80);
        checkOutput("bound_req0_size", reqSizeAt(baseReq), 64'd512);
`endif

        // Backpressure: request held stable while req_ready is low
        req_ready = 1'b0;
        baseReq   = reqAddrQ.size();
        baseUpd   = updQ.size();
        applyStimulus(64'h2000, 36'd100);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_hold%0d_valid", i), 64'(req_valid), 64'd1);
            checkOutput($sformatf("bp_hold%0d_addr", i), req_address, 64'h2000);
            checkOutput($sformatf("bp_hold%0d_size", i), 64'(req_size), 64'd100);
            tick(1);
        end
        req_ready = 1'b1;
        waitDone(400, "bp_done_seen");
        tick(10);
        checkOutput("bp_req_count", 64'(reqAddrQ.size() - baseReq), 64'd1);
        checkOutput("bp_upd_count", 64'(updQ.size() - baseUpd), 64'd1);
        checkOutput("bp_upd_size", updAt(baseUpd), 64'd100);

        // Credit limit (2 outstanding), then accept/completion collision and drain
        autoRsp  = 1'b0;
        baseReq  = reqAddrQ.size();
        baseDone = doneCount;
        applyStimulus(64'h3000, 36'd2048);
        tick(60);
        checkOutput("credit_req_count", 64'(reqAddrQ.size() - baseReq), 64'd2);
        checkOutput("credit_valid_low", 64'(req_valid), 64'd0);
        checkOutput("credit_outstanding", 64'(dut.outstanding_q), 64'd2);
        pulseRsp();
        tick(2);
        checkOutput("credit_third_count", 64'(reqAddrQ.size() - baseReq), 64'd3);
        checkOutput("credit_third_addr", reqAddrAt(baseReq + 2), 64'h3400);
        checkOutput("credit_third_size", reqSizeAt(baseReq + 2), 64'd512);
        req_ready = 1'b0;
        tick(20);
        checkOutput("credit_fourth_blocked", 64'(req_valid), 64'd0);
        pulseRsp();
        tick(1);
        checkOutput("credit_fourth_valid", 64'(req_valid), 64'd1);
        checkOutput("credit_fourth_addr", req_address, 64'h3600);
        checkOutput("credit_fourth_outst", 64'(dut.outstanding_q), 64'd1);
        req_ready = 1'b1;
        pulseRsp();
        tick(1);
        checkOutput("collision_outstanding", 64'(dut.outstanding_q), 64'd1);
        checkOutput("collision_update", 64'(param_update), 64'd1);
        checkOutput("collision_upd_size", 64'(param_size), 64'd512);
        tick(20);
        checkOutput("drain_busy_pending", 64'(busy), 64'd1);
        checkOutput("drain_no_done_yet", 64'(doneCount - baseDone), 64'd0);
        pulseRsp();
        tick(1);
        checkOutput("drain_done_pulse", 64'(done), 64'd1);
        checkOutput("drain_busy_drop", 64'(busy), 64'd0);
        tick(1);
        checkOutput("drain_done_single", 64'(done), 64'd0);

        // Empty stream: no request, done within 2 cycles
        baseReq = reqAddrQ.size();
        applyStimulus(64'h5000, 36'd0);
        tick(1);
        checkOutput("empty_no_valid", 64'(req_valid), 64'd0);
        tick(1);
        checkOutput("empty_done", 64'(done), 64'd1);
        tick(1);
        checkOutput("empty_done_single", 64'(done), 64'd0);
        checkOutput("empty_no_req", 64'(reqAddrQ.size() - baseReq), 64'd0);

        // Reset mid-stream with 2 outstanding, then restart
        applyStimulus(64'h6000, 36'd2048);
        tick(60);
        checkOutput("rstmid_pre_outst", 64'(dut.outstanding_q), 64'd2);
        checkOutput("rstmid_pre_state", 64'(dut.state_q), 64'(ST_ISSUE));
        rst = 1'b1;
        tick(1);
        checkAllClear("rstmid");
        rst = 1'b0;
        tick(2);
        autoRsp = 1'b1;
        baseReq = reqAddrQ.size();
        applyStimulus(64'h0, 36'd64);
        waitDone(400, "restart_done_seen");
        tick(10);
        checkOutput("restart_req_count", 64'(reqAddrQ.size() - baseReq), 64'd1);
        checkOutput("restart_req_addr", reqAddrAt(baseReq), 64'h0);
        checkOutput("restart_req_size", reqSizeAt(baseReq), 64'd64);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/burst_request_generator.md
# burst_request_generator

Issues memory read requests for a fetch stream by slicing the region held in the `address_incrementer` parameter registers into legal bursts. It sits directly downstream of `address_incrementer`. It consumes `transfer_parameters_address`, `_length`, `_valid` and `_complete`. It emits a request per burst to the memory read-request channel, and returns each accepted burst size to the incrementer via `transfer_parameters_update` / `_size`. It also bounds outstanding requests with a credit counter fed by read-completion pulses.

## Interface
Parameters:
- `MAX_BURST_BYTES`, default 512. Largest burst in bytes; a power of two, 16..4096.
- `MAX_OUTSTANDING`, default 4. Maximum number of accepted, uncompleted requests; 1..15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `param_address` in 64: current address, from `transfer_parameters_address`.
- `param_length` in 36: remaining bytes, from `transfer_parameters_length`.
- `param_valid` in 1: parameters stable, from `transfer_parameters_valid`.
- `param_complete` in 1: no data left, from `transfer_parameters_complete`.
- `param_update` out 1: one-cycle pulse that advances the incrementer.
- `param_size` out 36: bytes consumed by the accepted burst; valid with `param_update`.
- `req_valid` out 1: read request present.
- `req_ready` in 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_address` out 64: burst start address.
- `req_size` out 13: burst bytes, 1..4096.
- `rsp_done` in 1: one-cycle pulse per completed request.
- `busy` out 1: stream in progress or requests outstanding.
- `done` out 1: one-cycle pulse when the stream is fully issued and drained.

## Operation
States: IDLE, CALC, ISSUE, UPDATE, WAIT, DRAIN.

- **IDLE**
  - `param_valid & ~param_complete` → CALC; `busy` rises.
  - `param_valid & param_complete` → DRAIN (empty stream, no requests).
- **CALC**: register `size = min(param_length, MAX_BURST_BYTES, boundary)`, where `boundary = 4096 - param_address[11:0]`. Register `req_address = param_address`. → ISSUE.
- **ISSUE**
  - `req_valid` is high only while `outstanding < MAX_OUTSTANDING`.
  - `req_address` and `req_size` are held stable until accepted.
  - `req_valid` never drops once raised, unless `rst` is asserted.
  - On acceptance → UPDATE.
- **UPDATE**: drive `param_update = 1` and `param_size = {23'b0, size}` for exactly one cycle. → WAIT.
- **WAIT**: ignore parameters until `param_valid` is 1 again (the incrementer drops it for 4 cycles).
  - `param_complete` → DRAIN.
  - otherwise → CALC.
- **DRAIN**: wait for `outstanding == 0`, then pulse `done` and drop `busy` in the same cycle. → IDLE.

Credit counter `outstanding` (4 bits):
- +1 on request acceptance; −1 on `rsp_done`.
- Both in the same cycle: unchanged.
- `rsp_done` while at 0 is ignored; the counter saturates at 0.

Arithmetic and widths:
- `min` compares in 36-bit unsigned.
- `boundary` is 13-bit, range 1..4096.
- `size` is never 0 while `param_length > 0`.

## Timing
- Reset values:
  - `param_update`, `req_valid`, `busy`, `done` = 0.
  - `param_size`, `req_address`, `req_size` = 0.
  - `outstanding` = 0; state = IDLE.
- `rst` mid-operation: all of the above return to reset values the next cycle, and any pending request is dropped. The incrementer is reset by the same `rst`.
- From `param_valid` sampled in IDLE to `req_valid`: 2 cycles (IDLE→CALC→ISSUE), given credit is available.
- From acceptance to `param_update`: 1 cycle.
- Back-to-back bursts: the repeating cycle is UPDATE 1, WAIT ≥5, CALC 1, ISSUE ≥1 cycle, so the best case is 8 cycles per burst.
- `rsp_done` arriving in ISSUE frees credit in the same cycle: `req_valid` rises the next cycle.
- The last `rsp_done` in DRAIN produces `done` the next cycle.

## Configuration
Macro `BRG_4K_BOUNDARY_EN`:
- Defined: `boundary` participates in the `min`, so no burst crosses a 4 KB address boundary.
- Undefined: `size = min(param_length, MAX_BURST_BYTES)`, and bursts may straddle 4 KB boundaries.

## Structure
- Package `brg_pkg`:
  - state enum `brg_state_t`
  - `BRG_BOUNDARY_BYTES = 4096`
  - `BRG_SIZE_W = 13`
  - `BRG_LEN_W = 36`
  - `BRG_ADDR_W = 64`
- One sub-module, `burst_size_calc`: combinational `min` of length, max burst and boundary, with the boundary term under the macro.
- The FSM and credit counter live in the top module.

## Test plan
- Base split: macro on, address 0x1000, length 1300, `req_ready` = 1, `rsp_done` 3 cycles after each accept.
  - Requests are (0x1000, 512), (0x1200, 512), (0x1400, 276).
  - `param_size` pulses 512, 512, 276.
  - One `done` pulse.
- 4 KB boundary: address 0xF80, length 512.
  - Macro on: requests are (0xF80, 128), (0x1000, 384).
  - Macro off: single request (0xF80, 512).
- Credit limit: `MAX_OUTSTANDING` = 2, length 2048, no `rsp_done`.
  - Exactly 2 requests issue, then `req_valid` stays low.
  - One `rsp_done` → third request within 2 cycles.
- Backpressure: `req_ready` low for 5 cycles during ISSUE.
  - `req_valid`, `req_address` and `req_size` are held constant.
  - A single `param_update` follows acceptance.
- Empty stream and `rsp_done` collision:
  - `param_valid` = 1 with `param_complete` = 1: no request issues, and `done` pulses within 2 cycles.
  - Simultaneous accept and `rsp_done`: `outstanding` is unchanged.
- Reset mid-stream: `rst` asserted in ISSUE with `outstanding` = 2.
  - Next cycle: all outputs are 0 and the state is IDLE.
  - Re-initialising with address 0x0, length 64 issues (0x0, 64).
